// File: rtl/system_qsys_key_pkg.sv
// Shared definitions for the key input PIO:
// register offsets and edge-type encodings.
package system_qsys_key_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Select which debounced transitions count as a capture event.
  function automatic logic edge_pick(
    input int   et,
    input logic rise,
    input logic fall
  );
    logic hit;
    hit = rise | fall;
    if (et == EDGE_RISE) hit = rise;
    if (et == EDGE_FALL) hit = fall;
    return hit;
  endfunction

endpackage

// File: rtl/system_qsys_key_if.sv
// Avalon-MM slave bus bundle for the key PIO,
// zero-wait-state reads.
interface system_qsys_key_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/system_qsys_key_debounce.sv
// One key bit: 2-flop synchroniser, stability
// counter, debounced level and transition pulses.
module system_qsys_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Accept the synced level only after it has
  // differed for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State update; reset restores the idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      cnt_q   <= '0;
      level_q <= RESET_VAL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign rise  = level_d & ~level_q;
  assign fall  = ~level_d & level_q;

endmodule

// File: rtl/system_qsys_key.sv
// Push-button input PIO: debounced keys, per-bit
// edge capture with W1C, maskable level irq.
module system_qsys_key
  import system_qsys_key_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IN_RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  system_qsys_key_if.slave bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] level, rise, fall, set;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic             irq_q, irq_d;
  logic             wr;
  logic             unused_wdata;

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    system_qsys_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (IN_RESET_VALUE[gi])
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[gi]),
      .level  (level[gi]),
      .rise   (rise[gi]),
      .fall   (fall[gi])
    );
    assign set[gi] =
      edge_pick(EDGE_TYPE, rise[gi], fall[gi]);
  end

  assign wr = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  // Register writes; a new edge beats a W1C clear.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr && bus.address == ADDR_IRQMASK)
      mask_d = bus.writedata[WIDTH-1:0];
    if (wr && bus.address == ADDR_EDGECAP)
      clr = bus.writedata[WIDTH-1:0];
    ecap_d = (ecap_q & ~clr) | set;
    irq_d  = |(ecap_d & mask_d);
  end

  // Register file and registered interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      ecap_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      ecap_q <= ecap_d;
      irq_q  <= irq_d;
    end
  end

  // Combinational read mux, no side effects.
  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      ADDR_DATA:    bus.readdata = 32'(level);
      ADDR_IRQMASK: bus.readdata = 32'(mask_q);
      ADDR_EDGECAP: bus.readdata = 32'(ecap_q);
      default:      bus.readdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_system_qsys_key.sv
// Scoreboard bench: falling-edge and any-edge
// instances against a windowed debounce model.
module tb_system_qsys_key;
  import system_qsys_key_pkg::*;

  localparam int W = 4;
  localparam int N = 8;
  localparam int K_IDLE = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        irq1;
    logic        irq2;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic         irq1, irq2;

  int checks = 0;
  int failures = 0;

  exp_t         exp_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_deb, m_mask, m_ecap1, m_ecap2;

  system_qsys_key_if bus1();
  system_qsys_key_if bus2();

  always #5 clk = ~clk;

  system_qsys_key #(
    .WIDTH(W), .DEBOUNCE_CYCLES(N),
    .EDGE_TYPE(EDGE_FALL)
  ) u_fall (
    .clk(clk), .reset_n(reset_n),
    .bus(bus1.slave), .in_port(in_port),
    .irq(irq1)
  );

  system_qsys_key #(
    .WIDTH(W), .DEBOUNCE_CYCLES(N),
    .EDGE_TYPE(EDGE_ANY)
  ) u_any (
    .clk(clk), .reset_n(reset_n),
    .bus(bus2.slave), .in_port(in_port),
    .irq(irq2)
  );

  task automatic model_reset();
    m_deb   = '1;
    m_mask  = '0;
    m_ecap1 = '0;
    m_ecap2 = '0;
    hist.delete();
    repeat (N + 2) hist.push_back('1);
  endtask

  // A key flips once the synced samples seen before
  // the last N edges all disagree with its level.
  task automatic model_step();
    logic [W-1:0] flip, nxt, fall, clr;
    int s;
    bit all;
    hist.push_back(in_port);
    s = hist.size();
    flip = '0;
    for (int i = 0; i < W; i++) begin
      all = 1'b1;
      for (int k = s - 2 - N; k <= s - 3; k++)
        if (hist[k][i] == m_deb[i]) all = 1'b0;
      flip[i] = all;
    end
    nxt  = m_deb ^ flip;
    fall = flip & ~nxt;
    clr  = '0;
    if (bus1.chipselect && !bus1.write_n) begin
      if (bus1.address == 2'd2)
        m_mask = bus1.writedata[W-1:0];
      if (bus1.address == 2'd3)
        clr = bus1.writedata[W-1:0];
    end
    m_ecap1 = (m_ecap1 & ~clr) | fall;
    m_ecap2 = (m_ecap2 & ~clr) | flip;
    m_deb   = nxt;
    void'(hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  function automatic logic [31:0] exp_read(
    input logic [1:0] a, input logic [W-1:0] ec
  );
    case (a)
      2'd0:    return 32'(m_deb);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(ec);
      default: return 32'd0;
    endcase
  endfunction

  task automatic op(
    input int k, input logic [1:0] a,
    input logic [31:0] d
  );
    exp_t e;
    @(negedge clk);
    bus1.chipselect = (k != K_IDLE);
    bus1.write_n    = (k != K_WR);
    bus1.address    = a;
    bus1.writedata  = d;
    bus2.chipselect = bus1.chipselect;
    bus2.write_n    = bus1.write_n;
    bus2.address    = a;
    bus2.writedata  = d;
    if (k == K_RD) begin
      e.addr = a;
      e.rd1  = exp_read(a, m_ecap1);
      e.rd2  = exp_read(a, m_ecap2);
      e.irq1 = reset_n && |(m_ecap1 & m_mask);
      e.irq2 = reset_n && |(m_ecap2 & m_mask);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // Monitor: every presented read is popped/compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus1.chipselect && bus1.write_n) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rd_fall_a%0d", e.addr),
              bus1.readdata, e.rd1);
          chk($sformatf("rd_any_a%0d", e.addr),
              bus2.readdata, e.rd2);
          chk("irq_fall", 32'(irq1), 32'(e.irq1));
          chk("irq_any", 32'(irq2), 32'(e.irq2));
        end
      end
    end
  end

  task automatic rd_n(input int n, input logic [1:0] a);
    repeat (n) op(K_RD, a, 32'd0);
  endtask

  initial begin
    int r;
    bus1.chipselect = 1'b0;
    bus1.write_n    = 1'b1;
    bus1.address    = 2'd0;
    bus1.writedata  = '0;
    bus2.chipselect = 1'b0;
    bus2.write_n    = 1'b1;
    bus2.address    = 2'd0;
    bus2.writedata  = '0;

    // Reset with keys low: idle level still reads F.
    rd_n(3, 2'd0);
    op(K_IDLE, 2'd0, 0);
    reset_n = 1'b1;
    in_port = 4'hF;
    rd_n(4, 2'd3);

    // Clean press of key0, sampled every cycle.
    op(K_IDLE, 2'd0, 0);
    in_port[0] = 1'b0;
    for (int i = 0; i < 14; i++)
      op(K_RD, (i % 2 == 0) ? 2'd0 : 2'd3, 0);

    // Bouncing key1, then held low.
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) in_port[1] = ~in_port[1];
      op(K_RD, (i % 2 == 0) ? 2'd0 : 2'd3, 0);
    end
    in_port[1] = 1'b0;
    rd_n(14, 2'd3);

    // Mask key1 and walk through W1C clears.
    op(K_WR, 2'd2, 32'h2);
    rd_n(2, 2'd2);
    op(K_WR, 2'd3, 32'h1);
    rd_n(2, 2'd3);
    op(K_WR, 2'd3, 32'h2);
    rd_n(2, 2'd3);

    // Clear of bit2 lands on its falling edge.
    op(K_IDLE, 2'd0, 0);
    in_port[2] = 1'b0;
    repeat (8) op(K_IDLE, 2'd0, 0);
    op(K_WR, 2'd3, 32'h4);
    rd_n(3, 2'd3);

    // Release all keys: any-edge sees rises.
    in_port = 4'hF;
    rd_n(14, 2'd3);
    op(K_WR, 2'd3, 32'hF);
    rd_n(2, 2'd3);

    // Press/release key3 with a clear between.
    in_port[3] = 1'b0;
    rd_n(13, 2'd3);
    op(K_WR, 2'd3, 32'hF);
    in_port[3] = 1'b1;
    rd_n(13, 2'd3);

    // Data/reserved writes are ignored.
    op(K_WR, 2'd0, 32'h0);
    op(K_WR, 2'd1, 32'hFFFF_FFFF);
    rd_n(2, 2'd0);
    rd_n(2, 2'd1);

    // Reset in the middle of a key3 debounce.
    in_port[3] = 1'b0;
    repeat (5) op(K_IDLE, 2'd0, 0);
    reset_n = 1'b0;
    rd_n(2, 2'd0);
    op(K_IDLE, 2'd0, 0);
    reset_n = 1'b1;
    in_port[3] = 1'b1;
    rd_n(14, 2'd3);

    // Randomised keys and bus traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0)
        in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 599) == 0) begin
        op(K_IDLE, 2'd0, 0);
        reset_n = 1'b0;
        op(K_RD, 2'd3, 0);
        op(K_IDLE, 2'd0, 0);
        reset_n = 1'b1;
      end
      r = $urandom_range(0, 9);
      if (r <= 5)
        op(K_RD, 2'($urandom_range(0, 3)), 0);
      else if (r == 6)
        op(K_WR, 2'd2, $urandom);
      else if (r == 7 && $urandom_range(0, 3) == 0)
        op(K_WR, 2'd3, $urandom);
      else if (r == 8)
        op(K_WR, 2'($urandom_range(0, 1)), $urandom);
      else
        op(K_IDLE, 2'd0, 0);
    end

    op(K_IDLE, 2'd0, 0);
    op(K_IDLE, 2'd0, 0);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
